// File: rtl/blink_detector.sv
// Monitors an asynchronous toggle line: reports edge-to-edge intervals in clocks,
// flags a stable half-period (blinking) and a line that has stopped toggling (stuck).
module blink_detector #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             led_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             blinking_o,
  output logic             stuck_o
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURED, LOCKED} state_t;

  logic             s1_q, s2_q, s3_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lastp_q, lastp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             blink_q, blink_d;
  logic             stuck_q, stuck_d;

  logic             edge_w;
  logic             timeout_w;
  logic [CNT_W-1:0] intvl_w;

  always_comb begin
    edge_w    = s2_q ^ s3_q;
    intvl_w   = cnt_q + CNT_W'(1);
    // An edge landing on the last allowed count wins over the timeout.
    timeout_w = !edge_w && (cnt_q == CNT_W'(TIMEOUT - 1)) && (state_q != IDLE);

    state_d  = state_q;
    lastp_d  = lastp_q;
    period_d = period_q;
    pv_d     = 1'b0;
    stuck_d  = stuck_q;

    if (edge_w)                cnt_d = '0;
    else if (state_q != IDLE)  cnt_d = cnt_q + CNT_W'(1);
    else                       cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (edge_w) begin
          state_d = ARMED;
          stuck_d = 1'b0;
        end
      end
      ARMED: begin
        if (edge_w) begin
          state_d  = MEASURED;
          period_d = intvl_w;
          pv_d     = 1'b1;
          lastp_d  = intvl_w;
        end else if (timeout_w) begin
          state_d = IDLE;
          stuck_d = 1'b1;
        end
      end
      MEASURED, LOCKED: begin
        if (edge_w) begin
          period_d = intvl_w;
          pv_d     = 1'b1;
          if (intvl_w == lastp_q) begin
            state_d = LOCKED;
          end else begin
            state_d = MEASURED;
            lastp_d = intvl_w;
          end
        end else if (timeout_w) begin
          state_d = IDLE;
          stuck_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    blink_d = (state_d == LOCKED);
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      lastp_q  <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      blink_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      s1_q     <= led_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lastp_q  <= lastp_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      blink_q  <= blink_d;
      stuck_q  <= stuck_d;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign blinking_o     = blink_q;
  assign stuck_o        = stuck_q;

endmodule

// File: tb/tb_blink_detector.sv
// Directed bench for blink_detector with TIMEOUT=20; expectations hand-derived from
// the three-cycle edge-to-output latency.
module tb_blink_detector;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 20;

  logic             clk;
  logic             rstn;
  logic             led_i;
  logic [CNT_W-1:0] period_o;
  logic             period_valid_o;
  logic             blinking_o;
  logic             stuck_o;

  int tests = 0;
  int fails = 0;

  blink_detector #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .led_i           (led_i),
    .period_o        (period_o),
    .period_valid_o  (period_valid_o),
    .blinking_o      (blinking_o),
    .stuck_o         (stuck_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic pv, input int per,
                         input logic bl, input logic st);
    chk({tag, ".pv"},     {31'd0, period_valid_o}, {31'd0, pv});
    chk({tag, ".period"}, {24'd0, period_o},       per);
    chk({tag, ".blink"},  {31'd0, blinking_o},     {31'd0, bl});
    chk({tag, ".stuck"},  {31'd0, stuck_o},        {31'd0, st});
  endtask

  // Flip led_i 'gap' clocks after the previous flip, then look at the result
  // three clocks later, when the detected edge has reached the outputs.
  task automatic step(input string tag, input int gap, input logic pv, input int per,
                      input logic bl, input logic st);
    if (gap > 3) begin
      tick(1);
      chk({tag, ".pv_drop"}, {31'd0, period_valid_o}, 32'd0);
      tick(gap - 4);
    end
    led_i = ~led_i;
    tick(3);
    chk_all(tag, pv, per, bl, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    led_i = 1'b0;
    tick(3);
    chk_all("reset", 1'b0, 0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick(4);
    chk_all("idle", 1'b0, 0, 1'b0, 1'b0);

    // Toggle every clock: first edge arms, then period 1 every cycle, lock on third edge.
    for (int i = 0; i < 10; i++) begin
      led_i = ~led_i;
      tick(1);
      if (i == 2) chk("tog_arm.pv", {31'd0, period_valid_o}, 32'd0);
      if (i >= 3) chk_all("tog", 1'b1, 1, (i >= 4), 1'b0);
    end
    tick(2);
    chk_all("tog_last", 1'b1, 1, 1'b1, 1'b0);

    // Line stops: timeout fires 20 clocks after the last edge.
    tick(19);
    chk_all("pre_timeout", 1'b0, 1, 1'b1, 1'b0);
    tick(1);
    chk_all("timeout", 1'b0, 1, 1'b0, 1'b1);

    // Next toggle clears stuck, no period pulse.
    step("unstick", 3, 1'b0, 1, 1'b0, 1'b0);

    // Every 5 clocks, then a 7 excursion, then exactly TIMEOUT.
    step("p5_a", 5, 1'b1, 5, 1'b0, 1'b0);
    step("p5_b", 5, 1'b1, 5, 1'b1, 1'b0);
    step("p5_c", 5, 1'b1, 5, 1'b1, 1'b0);
    step("p7_a", 7, 1'b1, 7, 1'b0, 1'b0);
    step("p7_b", 7, 1'b1, 7, 1'b1, 1'b0);
    step("p20",  20, 1'b1, 20, 1'b0, 1'b0);

    // Lock at 3, then reset mid-measurement.
    step("p3_a", 3, 1'b1, 3, 1'b0, 1'b0);
    step("p3_b", 3, 1'b1, 3, 1'b1, 1'b0);
    #2;
    rstn  = 1'b0;
    led_i = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 0, 1'b0, 1'b0);
    tick(2);
    rstn = 1'b1;
    tick(2);
    step("rst_arm", 3, 1'b0, 0, 1'b0, 1'b0);
    step("rst_b",   3, 1'b1, 3, 1'b0, 1'b0);
    step("rst_c",   3, 1'b1, 3, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
